// File: rtl/i2c_reg_master.sv
// Single-master I2C register sequencer: START, address, register, then either a data write or a
// repeated-START single-byte read, then STOP. Quarter-bit timing honours slave clock stretching.
module i2c_reg_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_dev,
   input  logic [7:0] cmd_reg,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       scl_drive,
   output logic       sda_drive,
   input  logic       scl_in,
   input  logic       sda_in
);

   typedef enum logic [3:0] {
      StIdle, StStart, StAddrW, StAckA, StReg, StAckR, StWdata, StAckW,
      StRstart, StAddrR, StAckAr, StRdata, StMnack, StStop, StDone
   } state_e;

   localparam logic [7:0] CntLast = 8'(CLK_DIV - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] phase_q, phase_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d;
   logic       rw_q, rw_d;
   logic [6:0] dev_q, dev_d;
   logic [7:0] reg_q, reg_d;
   logic [7:0] wd_q, wd_d;
   logic       nack_q, nack_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] rsp_rdata_q, rsp_rdata_d;
   logic       rsp_nack_q, rsp_nack_d;

   logic       scl_low, sda_low;
   logic       is_tx, is_ack, is_bit;
   logic [2:0] last_phase;
   logic       tick, phase_done, bit_done, sample;

   always_comb begin
      is_tx  = (state_q == StAddrW) || (state_q == StReg) || (state_q == StWdata) ||
               (state_q == StAddrR);
      is_ack = (state_q == StAckA) || (state_q == StAckR) || (state_q == StAckW) ||
               (state_q == StAckAr);
      is_bit = is_tx || is_ack || (state_q == StRdata) || (state_q == StMnack);
   end

   // Bus drive decode; purely from registered state so reset releases the bus at once.
   always_comb begin
      scl_low = 1'b0;
      sda_low = 1'b0;
      unique case (state_q)
         StStart: begin
            scl_low = (phase_q == 3'd3);
            sda_low = (phase_q >= 3'd2);
         end
         StRstart: begin
            scl_low = (phase_q == 3'd0) || (phase_q == 3'd4);
            sda_low = (phase_q >= 3'd3);
         end
         StStop: begin
            scl_low = (phase_q == 3'd0);
            sda_low = (phase_q <= 3'd1);
         end
         StAddrW, StReg, StWdata, StAddrR: begin
            scl_low = (phase_q < 3'd2);
            sda_low = ~sh_q[7];
         end
         StAckA, StAckR, StAckW, StAckAr, StRdata, StMnack: begin
            scl_low = (phase_q < 3'd2);
         end
         default: ;
      endcase
   end

   assign scl_drive = scl_low;
   assign sda_drive = sda_low;
   assign cmd_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StDone);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_nack  = rsp_nack_q;

   // While SCL is released the timer only counts once the line is actually high.
   always_comb begin
      last_phase = (state_q == StRstart) ? 3'd4 : 3'd3;
      tick       = scl_low || scl_in;
      phase_done = tick && (cnt_q == CntLast);
      bit_done   = phase_done && (phase_q == last_phase);
      sample     = is_bit && tick && (phase_q == 3'd3) && (cnt_q == 8'd0);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      sh_d        = sh_q;
      rw_d        = rw_q;
      dev_d       = dev_q;
      reg_d       = reg_q;
      wd_d        = wd_q;
      nack_d      = nack_q;
      rdata_d     = rdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_nack_d  = rsp_nack_q;

      if (state_q == StIdle) begin
         cnt_d   = 8'd0;
         phase_d = 3'd0;
         bit_d   = 3'd0;
         if (cmd_valid) begin
            state_d = StStart;
            rw_d    = cmd_rw;
            dev_d   = cmd_dev;
            reg_d   = cmd_reg;
            wd_d    = cmd_wdata;
            nack_d  = 1'b0;
            rdata_d = 8'd0;
         end
      end else if (state_q == StDone) begin
         state_d = StIdle;
      end else begin
         if (tick) cnt_d = phase_done ? 8'd0 : cnt_q + 8'd1;
         if (phase_done) phase_d = (phase_q == last_phase) ? 3'd0 : phase_q + 3'd1;
         if (sample) begin
            if (is_ack && sda_in) nack_d = 1'b1;
            if (state_q == StRdata) sh_d = {sh_q[6:0], sda_in};
         end
         if (bit_done) begin
            if (is_tx) begin
               sh_d  = {sh_q[6:0], 1'b0};
               bit_d = bit_q + 3'd1;
            end else if (state_q == StRdata) begin
               bit_d = bit_q + 3'd1;
            end
            unique case (state_q)
               StStart: begin
                  state_d = StAddrW;
                  sh_d    = {dev_q, 1'b0};
               end
               StAddrW: if (bit_q == 3'd7) state_d = StAckA;
               StAckA: begin
                  state_d = nack_q ? StStop : StReg;
                  sh_d    = reg_q;
               end
               StReg:   if (bit_q == 3'd7) state_d = StAckR;
               StAckR: begin
                  if (nack_q) begin
                     state_d = StStop;
                  end else if (rw_q) begin
                     state_d = StRstart;
                  end else begin
                     state_d = StWdata;
                     sh_d    = wd_q;
                  end
               end
               StWdata: if (bit_q == 3'd7) state_d = StAckW;
               StAckW:  state_d = StStop;
               StRstart: begin
                  state_d = StAddrR;
                  sh_d    = {dev_q, 1'b1};
               end
               StAddrR: if (bit_q == 3'd7) state_d = StAckAr;
               StAckAr: state_d = nack_q ? StStop : StRdata;
               StRdata: begin
                  if (bit_q == 3'd7) begin
                     state_d = StMnack;
                     rdata_d = sh_q;
                  end
               end
               StMnack: state_d = StStop;
               StStop: begin
                  state_d     = StDone;
                  rsp_rdata_d = rdata_q;
                  rsp_nack_d  = nack_q;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         phase_q     <= 3'd0;
         bit_q       <= 3'd0;
         sh_q        <= 8'd0;
         rw_q        <= 1'b0;
         dev_q       <= 7'd0;
         reg_q       <= 8'd0;
         wd_q        <= 8'd0;
         nack_q      <= 1'b0;
         rdata_q     <= 8'd0;
         rsp_rdata_q <= 8'd0;
         rsp_nack_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         sh_q        <= sh_d;
         rw_q        <= rw_d;
         dev_q       <= dev_d;
         reg_q       <= reg_d;
         wd_q        <= wd_d;
         nack_q      <= nack_d;
         rdata_q     <= rdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_nack_q  <= rsp_nack_d;
      end
   end

endmodule
